// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   32-entry MIPS register file (2 combinational read ports, 1 write port)
//   with a per-register pending-write scoreboard that stalls ID on RAW hazards.
//
// Ports
//   clk, rst              rising-edge clock, async active-high reset
//   rs_addr/rs_used       read port A address, instruction reads rs
//   rt_addr/rt_used       read port B address, instruction reads rt
//   rs_data/rt_data       read data, combinational, write-through bypassed
//   iss_en/iss_addr       ID issues a write to iss_addr
//   wb_en/wb_addr/wb_data WB retires a write (and writes the register)
//   stall                 hold ID/IF this cycle, combinational
//   err                   sticky: a retire arrived with nothing pending
module reg_file_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_PEND = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic              rs_used,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rt_used,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              err
);
    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = $clog2(MAX_PEND + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  cnt  [NREG];
    logic [NREG-1:0]   inc_v;
    logic [NREG-1:0]   dec_v;
    logic              busy_rs;
    logic              busy_rt;
    logic              full_iss;
    logic              err_set;

    // Reads: r0 hardwired to zero, then same-cycle write-back bypass.
    assign rs_data = (rs_addr == '0) ? '0 :
                     (wb_en && wb_addr == rs_addr) ? wb_data : regs[rs_addr];
    assign rt_data = (rt_addr == '0) ? '0 :
                     (wb_en && wb_addr == rt_addr) ? wb_data : regs[rt_addr];

    // Retire decode; r0 is never tracked.
    always_comb begin
        dec_v = '0;
        if (wb_en && wb_addr != '0)
            dec_v[wb_addr] = 1'b1;
    end

    // A retire this cycle discounts one pending write, so the consumer can
    // proceed using the bypassed data instead of waiting another cycle.
    assign busy_rs  = cnt[rs_addr] > CNT_W'(dec_v[rs_addr]);
    assign busy_rt  = cnt[rt_addr] > CNT_W'(dec_v[rt_addr]);
    assign full_iss = iss_en && (iss_addr != '0) && (cnt[iss_addr] == CNT_MAX)
                      && !dec_v[iss_addr];

    // Stall looks only at registered counts, so an instruction reading its
    // own destination never stalls on itself.
    assign stall = (rs_used && busy_rs) || (rt_used && busy_rt) || full_iss;

    // Issue decode is gated by stall: a stalled issue is re-presented later.
    always_comb begin
        inc_v = '0;
        if (iss_en && iss_addr != '0 && !stall)
            inc_v[iss_addr] = 1'b1;
    end

    assign err_set = wb_en && (wb_addr != '0) && !inc_v[wb_addr]
                     && (cnt[wb_addr] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            err <= 1'b0;
        end else begin
            if (wb_en && wb_addr != '0)
                regs[wb_addr] <= wb_data;
            for (int r = 1; r < NREG; r++) begin
                if (inc_v[r] && !dec_v[r])
                    cnt[r] <= cnt[r] + CNT_W'(1);
                else if (dec_v[r] && !inc_v[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
            if (err_set)
                err <= 1'b1;
        end
    end

endmodule
